udp_rx_pkt_buf: RTL and testbench



---
 rtl/udp_rx_pkg.sv | 31 +++
 rtl/udp_sdp_ram.sv | 30 +++
 rtl/udp_rx_pkt_buf.sv | 179 +++++++++++++++++
 tb/tb_udp_rx_pkt_buf.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_pkg.sv
// rtl/udp_rx_pkg.sv - shared types and helpers for the UDP receive packet buffer
// Contents:
//   rd_state_t      read-side FSM states
//   keep_from_len   byte enables of the final word from len[1:0]
//   words_from_len  number of 32-bit words holding len bytes, ceil(len/4)
package udp_rx_pkg;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_VALID = 2'd2
    } rd_state_t;

    function automatic logic [3:0] keep_from_len(input logic [1:0] len_lo);
        logic [3:0] keep;
        case (len_lo)
            2'd1:    keep = 4'b1000;
            2'd2:    keep = 4'b1100;
            2'd3:    keep = 4'b1110;
            default: keep = 4'b1111;
        endcase
        return keep;
    endfunction

    function automatic logic [15:0] words_from_len(input logic [15:0] len);
        logic [16:0] rounded;
        rounded = {1'b0, len} + 17'd3;
        return {1'b0, rounded[16:2]};
    endfunction

endpackage

// File: rtl/udp_sdp_ram.sv
// rtl/udp_sdp_ram.sv - simple dual-port RAM, synchronous write, registered read
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address, sampled every cycle
//   o_rdata  read data, one cycle after i_raddr
module udp_sdp_ram #(
    parameter int WIDTH = 32,
    parameter int AW    = 9
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [2**AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/udp_rx_pkt_buf.sv
// rtl/udp_rx_pkt_buf.sv - commit/rollback packet buffer behind the UDP receive stage
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   rec_data_en, rec_data     incoming payload words, first byte in [31:24]
//   rec_end, rec_data_num     end of payload and its byte count
//   err_flag                  receive error, sampled with rec_end
//   m_valid, m_ready          output word handshake
//   m_data, m_keep, m_last    output word, byte enables, last-word marker
//   m_len                     byte length of the packet being replayed
//   buf_free                  free data-RAM words (pending words count as used)
//   pkt_ok_cnt, pkt_drop_cnt  saturating committed / dropped packet counters
import udp_rx_pkg::*;

module udp_rx_pkt_buf #(
    parameter int ADDR_W      = 9,
    parameter int LEN_AW      = 4,
    parameter bit DROP_ON_ERR = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rec_data_en,
    input  logic [31:0]       rec_data,
    input  logic              rec_end,
    input  logic [15:0]       rec_data_num,
    input  logic              err_flag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data,
    output logic [3:0]        m_keep,
    output logic              m_last,
    output logic [15:0]       m_len,
    output logic [ADDR_W:0]   buf_free,
    output logic [15:0]       pkt_ok_cnt,
    output logic [15:0]       pkt_drop_cnt
);

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_AW:0] LF_DEPTH = {1'b1, {LEN_AW{1'b0}}};

    // r_wr_ptr runs ahead speculatively; r_wr_base marks the start of the
    // packet still being received so a failed packet can be rolled back.
    logic [ADDR_W:0] r_wr_ptr, r_wr_base, r_rd_ptr;
    logic [LEN_AW:0] r_lf_wr, r_lf_rd;
    logic [15:0]     r_pend_words;
    logic            r_ovf;
    logic [15:0]     r_words_left;
    logic            r_first;
    rd_state_t       r_state;

    logic [ADDR_W:0]   w_used, w_wr_ptr_nxt;
    logic              w_full, w_wr_fire, w_ovf_nxt;
    logic [15:0]       w_pend_nxt;
    logic              w_lf_full, w_lf_empty, w_commit, w_rd_hs;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [31:0]       w_dram_q;
    logic [15:0]       w_lram_q, w_first_words;

    assign w_used       = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_used == DEPTH);
    assign w_wr_fire    = rec_data_en & ~w_full;
    assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_fire};
    assign w_pend_nxt   = r_pend_words + {15'd0, w_wr_fire};
    assign w_ovf_nxt    = r_ovf | (rec_data_en & w_full);
    assign w_lf_full    = ((r_lf_wr - r_lf_rd) == LF_DEPTH);
    assign w_lf_empty   = (r_lf_wr == r_lf_rd);
    assign buf_free     = DEPTH - w_used;

    // A word arriving together with rec_end is already included via the
    // *_nxt views, so it is judged as part of its own packet.
    assign w_commit = rec_end & ~w_ovf_nxt & ~w_lf_full & (rec_data_num != 16'd0)
                    & (w_pend_nxt == words_from_len(rec_data_num))
                    & ~(DROP_ON_ERR & err_flag);

    // Read address looks one word ahead on a handshake so the next word is
    // already in the RAM output register when R_FETCH runs.
    assign w_rd_hs   = (r_state == R_VALID) & m_ready;
    assign w_rd_addr = w_rd_hs ? (r_rd_ptr[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1})
                               : r_rd_ptr[ADDR_W-1:0];

    assign w_first_words = words_from_len(w_lram_q);

    udp_sdp_ram #(.WIDTH(32), .AW(ADDR_W)) u_data_ram (
        .i_clk   (sys_clk),
        .i_we    (w_wr_fire),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (rec_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_dram_q)
    );

    udp_sdp_ram #(.WIDTH(16), .AW(LEN_AW)) u_len_ram (
        .i_clk   (sys_clk),
        .i_we    (w_commit),
        .i_waddr (r_lf_wr[LEN_AW-1:0]),
        .i_wdata (rec_data_num),
        .i_raddr (r_lf_rd[LEN_AW-1:0]),
        .o_rdata (w_lram_q)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr     <= '0;
            r_wr_base    <= '0;
            r_lf_wr      <= '0;
            r_pend_words <= '0;
            r_ovf        <= 1'b0;
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else if (rec_end) begin
            r_pend_words <= '0;
            r_ovf        <= 1'b0;
            if (w_commit) begin
                r_wr_ptr  <= w_wr_ptr_nxt;
                r_wr_base <= w_wr_ptr_nxt;
                r_lf_wr   <= r_lf_wr + {{LEN_AW{1'b0}}, 1'b1};
                if (pkt_ok_cnt != 16'hFFFF) pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
            end else begin
                r_wr_ptr <= r_wr_base;
                if (pkt_drop_cnt != 16'hFFFF) pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
            end
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_pend_words <= w_pend_nxt;
            r_ovf        <= w_ovf_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= R_IDLE;
            r_rd_ptr     <= '0;
            r_lf_rd      <= '0;
            r_words_left <= '0;
            r_first      <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_keep       <= '0;
            m_last       <= 1'b0;
            m_len        <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (!w_lf_empty) begin
                        r_lf_rd <= r_lf_rd + {{LEN_AW{1'b0}}, 1'b1};
                        r_first <= 1'b1;
                        r_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    m_valid <= 1'b1;
                    m_data  <= w_dram_q;
                    r_first <= 1'b0;
                    r_state <= R_VALID;
                    // The popped length only appears on the length RAM output
                    // now, so the first beat takes length-derived fields from it.
                    if (r_first) begin
                        m_len        <= w_lram_q;
                        r_words_left <= w_first_words;
                        m_last       <= (w_first_words == 16'd1);
                        m_keep       <= (w_first_words == 16'd1) ? keep_from_len(w_lram_q[1:0]) : 4'hF;
                    end else begin
                        m_last <= (r_words_left == 16'd1);
                        m_keep <= (r_words_left == 16'd1) ? keep_from_len(m_len[1:0]) : 4'hF;
                    end
                end
                R_VALID: begin
                    if (m_ready) begin
                        m_valid      <= 1'b0;
                        r_rd_ptr     <= r_rd_ptr + {{ADDR_W{1'b0}}, 1'b1};
                        r_words_left <= r_words_left - 16'd1;
                        r_state      <= m_last ? R_IDLE : R_FETCH;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_pkt_buf.sv
// tb/tb_udp_rx_pkt_buf.sv - self-checking bench for udp_rx_pkt_buf
module tb_udp_rx_pkt_buf;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [2:0]  rec_en_v = 3'b000;
    logic [2:0]  rec_end_v = 3'b000;
    logic [31:0] rec_data = 32'd0;
    logic [15:0] rec_num = 16'd0;
    logic        err_flag = 1'b0;

    logic        m_ready_a [3];
    logic        m_valid_a [3];
    logic [31:0] m_data_a  [3];
    logic [3:0]  m_keep_a  [3];
    logic        m_last_a  [3];
    logic [15:0] m_len_a   [3];
    logic [15:0] ok_a      [3];
    logic [15:0] drop_a    [3];
    logic [9:0]  free_a    [3];
    logic [4:0]  free2;

    assign free_a[2] = {5'd0, free2};

    always #5 sys_clk = ~sys_clk;

    // Instance 0: defaults; 1: error flag ignored; 2: 16-word data RAM.
    udp_rx_pkt_buf #(.ADDR_W(9), .LEN_AW(4), .DROP_ON_ERR(1'b1)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rec_data_en(rec_en_v[0]), .rec_data(rec_data),
        .rec_end(rec_end_v[0]), .rec_data_num(rec_num), .err_flag(err_flag),
        .m_valid(m_valid_a[0]), .m_ready(m_ready_a[0]), .m_data(m_data_a[0]), .m_keep(m_keep_a[0]),
        .m_last(m_last_a[0]), .m_len(m_len_a[0]), .buf_free(free_a[0]),
        .pkt_ok_cnt(ok_a[0]), .pkt_drop_cnt(drop_a[0]));

    udp_rx_pkt_buf #(.ADDR_W(9), .LEN_AW(4), .DROP_ON_ERR(1'b0)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rec_data_en(rec_en_v[1]), .rec_data(rec_data),
        .rec_end(rec_end_v[1]), .rec_data_num(rec_num), .err_flag(err_flag),
        .m_valid(m_valid_a[1]), .m_ready(m_ready_a[1]), .m_data(m_data_a[1]), .m_keep(m_keep_a[1]),
        .m_last(m_last_a[1]), .m_len(m_len_a[1]), .buf_free(free_a[1]),
        .pkt_ok_cnt(ok_a[1]), .pkt_drop_cnt(drop_a[1]));

    udp_rx_pkt_buf #(.ADDR_W(4), .LEN_AW(4), .DROP_ON_ERR(1'b1)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rec_data_en(rec_en_v[2]), .rec_data(rec_data),
        .rec_end(rec_end_v[2]), .rec_data_num(rec_num), .err_flag(err_flag),
        .m_valid(m_valid_a[2]), .m_ready(m_ready_a[2]), .m_data(m_data_a[2]), .m_keep(m_keep_a[2]),
        .m_last(m_last_a[2]), .m_len(m_len_a[2]), .buf_free(free2),
        .pkt_ok_cnt(ok_a[2]), .pkt_drop_cnt(drop_a[2]));

    // Reference model: per instance, committed packets awaiting delivery.
    int         cap [3] = '{512, 512, 16};
    bit         drop_err [3] = '{1'b1, 1'b0, 1'b1};
    int         exp_len [3][$];
    logic [7:0] exp_bytes [3][$];
    int         beat_idx [3] = '{0, 0, 0};
    int         ok_m [3] = '{0, 0, 0};
    int         drop_m [3] = '{0, 0, 0};
    int         ready_mode = 0;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic int used_words(input int k);
        int s = 0;
        for (int i = 0; i < exp_len[k].size(); i++) s += (exp_len[k][i] + 3) / 4;
        return s - beat_idx[k];
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Scoreboard: checks every presented beat against the head packet and
    // chooses m_ready for the next edge.
    int         mon_l, mon_b;
    bit         mon_last, mon_rdy;
    logic [31:0] mon_ed, mon_mk;
    logic [3:0] mon_ek;

    always @(negedge sys_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!sys_rst_n) begin
                m_ready_a[k] = 1'b0;
            end else begin
                if (m_valid_a[k]) begin
                    n_vec++;
                    if (exp_len[k].size() == 0) begin
                        n_err++;
                        $display("FAIL beat_unexpected inst%0d: got data=%h len=%0d, required no beat", k, m_data_a[k], m_len_a[k]);
                    end else begin
                        mon_l = exp_len[k][0];
                        mon_b = beat_idx[k];
                        mon_last = (mon_b == (mon_l + 3) / 4 - 1);
                        mon_ed = 32'd0;
                        mon_mk = 32'd0;
                        for (int j = 0; j < 4; j++) begin
                            if (4 * mon_b + j < mon_l) begin
                                mon_ed[31 - 8 * j -: 8] = exp_bytes[k][4 * mon_b + j];
                                mon_mk[31 - 8 * j -: 8] = 8'hFF;
                            end
                        end
                        mon_ek = !mon_last ? 4'hF : (mon_l % 4 == 1) ? 4'h8 : (mon_l % 4 == 2) ? 4'hC : (mon_l % 4 == 3) ? 4'hE : 4'hF;
                        if ((m_data_a[k] & mon_mk) !== mon_ed || m_keep_a[k] !== mon_ek ||
                            m_last_a[k] !== mon_last || m_len_a[k] !== 16'(mon_l)) begin
                            n_err++;
                            $display("FAIL beat inst%0d beat%0d: got data=%h keep=%h last=%b len=%0d, required data=%h(mask %h) keep=%h last=%b len=%0d",
                                     k, mon_b, m_data_a[k], m_keep_a[k], m_last_a[k], m_len_a[k], mon_ed, mon_mk, mon_ek, mon_last, mon_l);
                        end
                    end
                end
                mon_rdy = (ready_mode == 2) ? 1'b1 : (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
                m_ready_a[k] = mon_rdy;
                if (m_valid_a[k] && mon_rdy && exp_len[k].size() > 0) begin
                    mon_l = exp_len[k][0];
                    beat_idx[k]++;
                    if (beat_idx[k] == (mon_l + 3) / 4) begin
                        for (int i = 0; i < mon_l; i++) void'(exp_bytes[k].pop_front());
                        void'(exp_len[k].pop_front());
                        beat_idx[k] = 0;
                    end
                end
            end
        end
    end

    task automatic send_pkt(input logic [2:0] mask, input int nwords, input int num,
                            input bit err, input int first_byte, input bit do_end);
        logic [7:0] b[$];
        bit end_on_last;
        int wexp, q, occ, fr;
        for (int i = 0; i < nwords * 4; i++) b.push_back(first_byte >= 0 ? 8'(first_byte + i) : 8'($urandom));
        end_on_last = do_end && nwords > 0 && ($urandom_range(0, 1) == 1);
        for (int w = 0; w < nwords; w++) begin
            rec_data = {b[4 * w], b[4 * w + 1], b[4 * w + 2], b[4 * w + 3]};
            rec_en_v = mask;
            rec_num  = 16'($urandom);
            err_flag = 1'($urandom);
            if (end_on_last && w == nwords - 1) begin
                rec_end_v = mask;
                rec_num   = 16'(num);
                err_flag  = err;
            end
            tick();
            rec_en_v  = 3'b000;
            rec_end_v = 3'b000;
            rec_data  = $urandom;
            if (!(end_on_last && w == nwords - 1)) repeat ($urandom_range(1, 3)) tick();
        end
        if (do_end && !end_on_last) begin
            rec_end_v = mask;
            rec_num   = 16'(num);
            err_flag  = err;
            tick();
            rec_end_v = 3'b000;
        end
        err_flag = 1'b0;
        if (do_end) begin
            for (int k = 0; k < 3; k++) begin
                if (mask[k]) begin
                    wexp = (num + 3) / 4;
                    q    = exp_len[k].size();
                    occ  = (q > 0) ? q - 1 : 0;   // head packet already taken by the reader
                    fr   = cap[k] - used_words(k);
                    if (!(drop_err[k] && err) && num != 0 && nwords == wexp && nwords <= fr && occ < 16) begin
                        ok_m[k]++;
                        exp_len[k].push_back(num);
                        for (int i = 0; i < num; i++) exp_bytes[k].push_back(b[i]);
                    end else begin
                        drop_m[k]++;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_len[0].size() + exp_len[1].size() + exp_len[2].size()) > 0 && t < 4000) begin
            tick();
            t++;
        end
        n_vec++;
        if ((exp_len[0].size() + exp_len[1].size() + exp_len[2].size()) > 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d/%0d/%0d packets still undelivered, required 0",
                     exp_len[0].size(), exp_len[1].size(), exp_len[2].size());
            for (int k = 0; k < 3; k++) begin
                exp_len[k].delete();
                exp_bytes[k].delete();
                beat_idx[k] = 0;
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (m_valid_a[k] !== 1'b0 || m_data_a[k] !== 32'd0 || m_keep_a[k] !== 4'd0 || m_last_a[k] !== 1'b0 ||
                m_len_a[k] !== 16'd0 || ok_a[k] !== 16'd0 || drop_a[k] !== 16'd0 || free_a[k] !== 10'(cap[k])) begin
                n_err++;
                $display("FAIL reset inst%0d: got v=%b d=%h k=%h l=%b len=%0d ok=%0d drop=%0d free=%0d, required zeros free=%0d",
                         k, m_valid_a[k], m_data_a[k], m_keep_a[k], m_last_a[k], m_len_a[k], ok_a[k], drop_a[k], free_a[k], cap[k]);
            end
        end
    endtask

    task automatic test_basic();
        ready_mode = 0;
        send_pkt(3'b011, 2, 8, 1'b0, 8'h01, 1'b1);
        repeat (5) tick();
        send_pkt(3'b011, 2, 5, 1'b0, 8'h11, 1'b1);
        drain();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (ok_a[k] !== 16'd2 || drop_a[k] !== 16'd0 || free_a[k] !== 10'd512) begin
                n_err++;
                $display("FAIL basic_counts inst%0d: got ok=%0d drop=%0d free=%0d, required ok=2 drop=0 free=512",
                         k, ok_a[k], drop_a[k], free_a[k]);
            end
        end
    endtask

    task automatic test_errors();
        send_pkt(3'b011, 3, 12, 1'b1, 8'h31, 1'b1);   // err_flag set
        repeat (3) tick();
        send_pkt(3'b011, 3, 16, 1'b0, -1, 1'b1);      // word count disagrees with byte count
        repeat (3) tick();
        send_pkt(3'b011, 1, 0, 1'b0, -1, 1'b1);       // zero-length
        drain();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (ok_a[k] !== 16'(ok_m[k]) || drop_a[k] !== 16'(drop_m[k]) || free_a[k] !== 10'd512) begin
                n_err++;
                $display("FAIL error_counts inst%0d: got ok=%0d drop=%0d free=%0d, required ok=%0d drop=%0d free=512",
                         k, ok_a[k], drop_a[k], free_a[k], ok_m[k], drop_m[k]);
            end
        end
    endtask

    task automatic test_overflow();
        send_pkt(3'b100, 20, 80, 1'b0, -1, 1'b1);
        tick();
        n_vec++;
        if (drop_a[2] !== 16'd1 || free_a[2] !== 10'd16 || ok_a[2] !== 16'd0) begin
            n_err++;
            $display("FAIL overflow_drop: got drop=%0d ok=%0d free=%0d, required drop=1 ok=0 free=16", drop_a[2], ok_a[2], free_a[2]);
        end
        send_pkt(3'b100, 2, 8, 1'b0, 8'h21, 1'b1);
        drain();
        n_vec++;
        if (ok_a[2] !== 16'd1 || free_a[2] !== 10'd16) begin
            n_err++;
            $display("FAIL overflow_next: got ok=%0d free=%0d, required ok=1 free=16", ok_a[2], free_a[2]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        logic [3:0]  k0;
        logic        l0;
        logic [15:0] n0;
        int t = 0;
        ready_mode = 1;
        send_pkt(3'b001, 4, 16, 1'b0, 8'h41, 1'b1);
        while (m_valid_a[0] !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        n_vec++;
        if (m_valid_a[0] !== 1'b1) begin
            n_err++;
            $display("FAIL stall_valid_timeout: got m_valid=%b, required 1", m_valid_a[0]);
        end
        d0 = m_data_a[0]; k0 = m_keep_a[0]; l0 = m_last_a[0]; n0 = m_len_a[0];
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (m_valid_a[0] !== 1'b1 || m_data_a[0] !== d0 || m_keep_a[0] !== k0 || m_last_a[0] !== l0 || m_len_a[0] !== n0) begin
                n_err++;
                $display("FAIL stall_stable cycle%0d: got v=%b d=%h k=%h l=%b len=%0d, required v=1 d=%h k=%h l=%b len=%0d",
                         i, m_valid_a[0], m_data_a[0], m_keep_a[0], m_last_a[0], m_len_a[0], d0, k0, l0, n0);
            end
        end
        ready_mode = 0;
        drain();
    endtask

    task automatic test_fifo_full();
        int ok0, drop0, nb;
        ok0 = ok_m[0];
        drop0 = drop_m[0];
        ready_mode = 1;
        // The reader pulls the first packet out of the length FIFO even while
        // stalled, so 16 more fit and only the 18th is refused.
        for (int i = 0; i < 18; i++) begin
            nb = $urandom_range(1, 8);
            send_pkt(3'b001, (nb + 3) / 4, nb, 1'b0, -1, 1'b1);
            tick();
        end
        n_vec++;
        if (ok_a[0] !== 16'(ok0 + 17) || drop_a[0] !== 16'(drop0 + 1) || free_a[0] !== 10'(512 - used_words(0))) begin
            n_err++;
            $display("FAIL fifo_full: got ok=%0d drop=%0d free=%0d, required ok=%0d drop=%0d free=%0d",
                     ok_a[0], drop_a[0], free_a[0], ok0 + 17, drop0 + 1, 512 - used_words(0));
        end
        ready_mode = 0;
        drain();
    endtask

    task automatic test_random();
        int nb, nw, num, r;
        bit err;
        for (int i = 0; i < 40; i++) begin
            nb  = $urandom_range(1, 32);
            nw  = (nb + 3) / 4;
            num = nb;
            r   = $urandom_range(0, 9);
            if (r == 0) num = nb + 4;
            if (r == 1) num = 0;
            err = ($urandom_range(0, 5) == 0);
            send_pkt(3'b011, nw, num, err, -1, 1'b1);
            repeat ($urandom_range(2, 8)) tick();
        end
        drain();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (ok_a[k] !== 16'(ok_m[k]) || drop_a[k] !== 16'(drop_m[k]) || free_a[k] !== 10'd512) begin
                n_err++;
                $display("FAIL random_counts inst%0d: got ok=%0d drop=%0d free=%0d, required ok=%0d drop=%0d free=512",
                         k, ok_a[k], drop_a[k], free_a[k], ok_m[k], drop_m[k]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        send_pkt(3'b111, 3, 0, 1'b0, -1, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (m_valid_a[k] !== 1'b0 || m_data_a[k] !== 32'd0 || m_keep_a[k] !== 4'd0 || m_last_a[k] !== 1'b0 ||
                m_len_a[k] !== 16'd0 || ok_a[k] !== 16'd0 || drop_a[k] !== 16'd0 || free_a[k] !== 10'(cap[k])) begin
                n_err++;
                $display("FAIL midreset inst%0d: got v=%b d=%h k=%h l=%b len=%0d ok=%0d drop=%0d free=%0d, required zeros free=%0d",
                         k, m_valid_a[k], m_data_a[k], m_keep_a[k], m_last_a[k], m_len_a[k], ok_a[k], drop_a[k], free_a[k], cap[k]);
            end
            exp_len[k].delete();
            exp_bytes[k].delete();
            beat_idx[k] = 0;
            ok_m[k] = 0;
            drop_m[k] = 0;
        end
        tick();
        sys_rst_n = 1'b1;
        tick();
        send_pkt(3'b001, 1, 4, 1'b0, 8'h51, 1'b1);
        drain();
        n_vec++;
        if (ok_a[0] !== 16'd1 || drop_a[0] !== 16'd0 || free_a[0] !== 10'd512) begin
            n_err++;
            $display("FAIL midreset_after: got ok=%0d drop=%0d free=%0d, required ok=1 drop=0 free=512", ok_a[0], drop_a[0], free_a[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_overflow();
        test_backpressure();
        test_fifo_full();
        test_random();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
